// File: rtl/vpu_pkg.sv
// vpu_pkg: shared SRAM geometry constants and the read-server FSM state type.
package vpu_pkg;

    localparam int SRAM_BANK_CNT_LG2   = 3;
    localparam int SRAM_BANK_DEPTH_LG2 = 10;
    localparam int SRAM_DATA_WIDTH     = 512;
    localparam int SRAM_PAR_LANES      = SRAM_DATA_WIDTH / 64;

    typedef enum logic [1:0] {
        SRV_IDLE,
        SRV_ACK,
        SRV_BURST,
        SRV_DRAIN
    } srv_state_e;

endpackage

// File: rtl/vpu_rd_lat_pipe.sv
// vpu_rd_lat_pipe: valid + bank-select delay line covering issue register plus bank macro latency.
module vpu_rd_lat_pipe
    import vpu_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_vld,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_busy
);

    logic [DEPTH-1:0]            r_vld;
    logic [DEPTH-1:0][SEL_W-1:0] r_sel;

    // shift issued beats toward the tap; clear drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_sel <= '0;
        end else begin
            r_vld <= {r_vld[DEPTH-2:0], i_vld};
            r_sel <= {r_sel[DEPTH-2:0], i_sel};
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_sel  = r_sel[DEPTH-1];
    assign o_busy = |r_vld;

endmodule

// File: rtl/vpu_sram_rd_server.sv
// vpu_sram_rd_server: terminates one VPU source port and serves its read bursts from one SRAM bank (optional lane parity check: VPU_SRAM_RD_PARITY_EN).
module vpu_sram_rd_server
    import vpu_pkg::*;
#(
    parameter int SRAM_BANK_CNT       = 2 ** vpu_pkg::SRAM_BANK_CNT_LG2,
    parameter int SRAM_BANK_DEPTH_LG2 = vpu_pkg::SRAM_BANK_DEPTH_LG2,
    parameter int SRAM_DATA_WIDTH     = vpu_pkg::SRAM_DATA_WIDTH,
    parameter int RD_LAT              = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     req,
    output logic                                     ack,
    input  logic [$clog2(SRAM_BANK_CNT)-1:0]         rid,
    input  logic [SRAM_BANK_DEPTH_LG2-1:0]           addr,
    input  logic                                     reb,
    input  logic                                     rlast,
    output logic [SRAM_DATA_WIDTH-1:0]               rdata,
    output logic                                     rvalid,
    output logic [SRAM_BANK_CNT-1:0]                 bank_ce,
    output logic [SRAM_BANK_DEPTH_LG2-1:0]           bank_addr,
    input  logic [SRAM_BANK_CNT*SRAM_DATA_WIDTH-1:0] bank_rdata,
    output logic                                     busy
`ifdef VPU_SRAM_RD_PARITY_EN
    ,
    input  logic [SRAM_BANK_CNT*(SRAM_DATA_WIDTH/64)-1:0] bank_rpar,
    output logic                                          par_err
`endif
);

    localparam int BANK_W = $clog2(SRAM_BANK_CNT);

    srv_state_e                 r_state;
    logic [BANK_W-1:0]          r_bank_sel;
    logic                       r_ack;
    logic                       r_busy;
    logic                       w_issue;
    logic                       w_tap_vld;
    logic                       w_pipe_busy;
    logic [BANK_W-1:0]          w_tap_sel;
    logic [SRAM_DATA_WIDTH-1:0] w_tap_data;

    assign w_issue = (r_state == SRV_BURST) && !reb;

    // burst handshake FSM; ack and busy are registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SRV_IDLE;
            r_bank_sel <= '0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                SRV_IDLE: begin
                    if (req) begin
                        r_state    <= SRV_ACK;
                        r_bank_sel <= rid;
                        r_ack      <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                SRV_ACK: begin
                    r_state <= SRV_BURST;
                    r_ack   <= 1'b0;
                end
                SRV_BURST: begin
                    if (!reb && rlast) r_state <= SRV_DRAIN;
                end
                SRV_DRAIN: begin
                    if (!w_pipe_busy) begin
                        r_state <= SRV_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SRV_IDLE;
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack  = r_ack;
    assign busy = r_busy;

    // register the bank strobe and address; the address holds between beats
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_ce   <= '0;
            bank_addr <= '0;
        end else begin
            bank_ce <= w_issue ? (SRAM_BANK_CNT'(1) << r_bank_sel) : '0;
            if (w_issue) bank_addr <= addr;
        end
    end

    vpu_rd_lat_pipe #(
        .DEPTH (RD_LAT + 1),
        .SEL_W (BANK_W)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_issue),
        .i_sel  (r_bank_sel),
        .o_vld  (w_tap_vld),
        .o_sel  (w_tap_sel),
        .o_busy (w_pipe_busy)
    );

    assign w_tap_data = bank_rdata[w_tap_sel*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];

    // capture the returning bank word in issue order; idle cycles read as zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= w_tap_vld;
            rdata  <= w_tap_vld ? w_tap_data : '0;
        end
    end

`ifdef VPU_SRAM_RD_PARITY_EN
    localparam int PAR_LANES = SRAM_DATA_WIDTH / 64;

    logic [PAR_LANES-1:0] w_tap_par;
    logic [PAR_LANES-1:0] w_lane_bad;

    assign w_tap_par = bank_rpar[w_tap_sel*PAR_LANES +: PAR_LANES];

    for (genvar l = 0; l < PAR_LANES; l++) begin : g_lane
        assign w_lane_bad[l] = ^w_tap_data[l*64 +: 64] ^ w_tap_par[l];
    end

    // flag a parity mismatch in the same cycle as the word it belongs to
    always_ff @(posedge clk) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= w_tap_vld && |w_lane_bad;
    end
`endif

endmodule
